alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Pipelined decode stage that sits in front of the 64-bit ALU (alu_64_bit).
- Accepts 32-bit RV64I instructions plus register operands over a valid/ready handshake.
- Produces the ALU 4-bit control code, operand A, and operand B (register value or sign-extended immediate).
- Registered output with a 2-entry skid buffer, so in_ready depends only on flops.

Parameters:
- XLEN, 64, operand/immediate width; must match the ALU width.
- SKID_DEPTH, 2, entries in the output buffer; only 2 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all buffered entries this cycle.
- in_valid  input  1  instruction and operands present.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  RV64I instruction word.
- in_rs1_val  input  XLEN  rs1 register value.
- in_rs2_val  input  XLEN  rs2 register value.
- out_valid  output  1  decoded op available.
- out_ready  input  1  ALU/execute consumes this cycle.
- out_opcode  output  4  ALU control code.
- out_a  output  XLEN  ALU operand A.
- out_b  output  XLEN  ALU operand B.
- out_rd  output  5  destination register; 0 for STORE/BRANCH.
- out_illegal  output  1  unsupported instruction (see Optional Feature).

Behaviour:
- ALU control codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- OP (0110011): opcode = {funct7[5], funct3}. A = rs1, B = rs2.
- OP-IMM (0010011): opcode = {(funct3==101) & instr[30], funct3}. B = sext(imm[11:0]). For shifts, B = zero-extended shamt instr[25:20]; funct6 must be 000000 or 010000.
- LOAD (0000011) and STORE (0100011): ADD. B = sext(I-imm) or sext(S-imm).
- BRANCH (1100011): BEQ/BNE map to SUB, BLT/BGE to SLT, BLTU/BGEU to SLTU. B = rs2. Funct3 010/011 are illegal.
- LUI (0110111): ADD, A = 0, B = sext({imm[31:12], 12'b0}).
- Any other major opcode is illegal: ADD, A = 0, B = 0.
- Handshake:
  - A transfer occurs on a side when valid & ready are both high.
  - Once out_valid is high, out_* are held stable until out_ready.
  - in_ready = !(buffer count == 2), registered.
- Buffer:
  - FIFO order, 2 entries, count 0..2.
  - Simultaneous push and pop: count is unchanged and order is preserved.
  - A push with count==2 cannot happen because in_ready is 0.
- Latency: 1 cycle. An accept at cycle N gives out_valid at N+1 when the buffer was empty.
- Flush:
  - Count goes to 0 next cycle; an in-flight push that same cycle is also dropped.
  - Flush takes priority over push and pop.
  - in_ready is 1 the following cycle.
- Reset:
  - out_valid = 0, in_ready = 1 (after the reset cycle), count = 0.
  - out_opcode = 0, out_a = 0, out_b = 0, out_rd = 0, out_illegal = 0.
  - Reset mid-stream discards all entries.
- Decode is combinational into the buffer write port. Outputs come from the head entry register.

Optional Feature:
- Macro: ALU_DECODE_ILLEGAL_EN.
- Defined:
  - out_illegal = 1 for unsupported major opcode, OP with funct7 not in {0000000, 0100000}, OP funct7=0100000 with funct3 not 000/101, bad shift funct6, or BRANCH funct3 010/011.
  - The entry is still delivered.
- Undefined: out_illegal is tied 0 and those encodings decode by the field rules above without checking.

Decomposition:
- Package alu_pkg:
  - localparams for the 10 ALU control codes (shared with alu_64_bit and its bench).
  - RV64I major-opcode constants.
  - XLEN default.
- Sub-module alu_op_decoder: pure combinational decode of instr, rs1, rs2 into opcode, a, b, rd, illegal.
- alu_decode_stage owns the skid buffer, handshake and flush.

Test Plan:
- OP SUB x3,x1,x2 (0x402081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, opcode=1000, a=5, b=7, rd=3.
- OP-IMM SRAI x1,x1,63 (0x43F0D093) -> opcode=1101, b=0x3F. ADDI x1,x0,-1 (0xFFF00093) -> opcode=0000, b=0xFFFF_FFFF_FFFF_FFFF.
- BLTU (funct3=110) -> opcode=0011, rd=0. BEQ -> opcode=1000. LW -> opcode=0000, b=sext(imm).
- Backpressure: out_ready=0, push 3 valid ops -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Release out_ready -> both emerge in order, outputs stable while stalled.
- Simultaneous push/pop at count=1 -> count stays 1, order intact. Flush with count=2 plus a concurrent push -> out_valid=0 next cycle, nothing delivered.
- With ALU_DECODE_ILLEGAL_EN: instr 0x0000007F -> out_illegal=1, opcode=0000, a=b=0. Without the macro: out_illegal=0 in the same case. Assert rst mid-stream -> all outputs 0, in_ready=1 after.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV64I major opcodes and the default datapath width.
// Used by alu_64_bit, its decode stage and both benches.
package alu_pkg;

    localparam int unsigned XLEN_DEF = 64;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSll  = 4'b0001;
    localparam logic [3:0] AluSlt  = 4'b0010;
    localparam logic [3:0] AluSltu = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSrl  = 4'b0101;
    localparam logic [3:0] AluOr   = 4'b0110;
    localparam logic [3:0] AluAnd  = 4'b0111;
    localparam logic [3:0] AluSub  = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1101;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV64I decode into ALU control code, operands and destination register.
// Illegal-encoding detection is compiled in only when ALU_DECODE_ILLEGAL_EN is defined.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    output logic [3:0]      opcode_o,
    output logic [XLEN-1:0] a_o,
    output logic [XLEN-1:0] b_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);

    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign funct3 = instr_i[14:12];
    assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u  = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
    assign shamt  = {{(XLEN-6){1'b0}}, instr_i[25:20]};

    always_comb begin
        opcode_o  = AluAdd;
        a_o       = '0;
        b_o       = '0;
        rd_o      = '0;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OpcOp: begin
                opcode_o = {instr_i[30], funct3};
                a_o      = rs1_val_i;
                b_o      = rs2_val_i;
                rd_o     = instr_i[11:7];
`ifdef ALU_DECODE_ILLEGAL_EN
                illegal_o = !((instr_i[31:25] == 7'b0000000) ||
                              ((instr_i[31:25] == 7'b0100000) &&
                               (funct3 == 3'b000 || funct3 == 3'b101)));
`endif
            end
            OpcOpImm: begin
                opcode_o = {(funct3 == 3'b101) & instr_i[30], funct3};
                a_o      = rs1_val_i;
                rd_o     = instr_i[11:7];
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    b_o = shamt;
`ifdef ALU_DECODE_ILLEGAL_EN
                    illegal_o = (instr_i[31:26] != 6'b000000) &&
                                (instr_i[31:26] != 6'b010000);
`endif
                end else begin
                    b_o = imm_i;
                end
            end
            OpcLoad: begin
                a_o  = rs1_val_i;
                b_o  = imm_i;
                rd_o = instr_i[11:7];
            end
            OpcStore: begin
                a_o = rs1_val_i;
                b_o = imm_s;
            end
            OpcBranch: begin
                a_o = rs1_val_i;
                b_o = rs2_val_i;
                case (funct3[2:1])
                    2'b00:   opcode_o = AluSub;
                    2'b10:   opcode_o = AluSlt;
                    2'b11:   opcode_o = AluSltu;
                    default: begin
                        opcode_o = AluAdd;
`ifdef ALU_DECODE_ILLEGAL_EN
                        illegal_o = 1'b1;
`endif
                    end
                endcase
            end
            OpcLui: begin
                b_o  = imm_u;
                rd_o = instr_i[11:7];
            end
            default: begin
`ifdef ALU_DECODE_ILLEGAL_EN
                illegal_o = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage in front of alu_64_bit: decoder feeding a 2-entry FIFO skid buffer.
// Optional ALU_DECODE_ILLEGAL_EN enables out_illegal reporting in the decoder.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_opcode,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam int unsigned EntW = 4 + 2 * XLEN + 5 + 1;
    localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);

    logic [3:0]      dec_opcode;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [4:0]      dec_rd;
    logic            dec_illegal;
    logic [EntW-1:0] dec_entry;

    logic [EntW-1:0] head_q, head_d;
    logic [EntW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            push, pop;

    alu_op_decoder #(
        .XLEN (XLEN)
    ) u_dec (
        .instr_i   (in_instr),
        .rs1_val_i (in_rs1_val),
        .rs2_val_i (in_rs2_val),
        .opcode_o  (dec_opcode),
        .a_o       (dec_a),
        .b_o       (dec_b),
        .rd_o      (dec_rd),
        .illegal_o (dec_illegal)
    );

    assign dec_entry = {dec_illegal, dec_rd, dec_b, dec_a, dec_opcode};
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) head_d = dec_entry;
                    else               tail_d = dec_entry;
                    count_d = count_q + CntW'(1);
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - CntW'(1);
                end
                // push implies count < 2, so a concurrent pop leaves exactly one entry
                2'b11: head_d = (count_q == CntW'(1)) ? dec_entry : tail_q;
                default: ;
            endcase
        end
        in_ready_d = (count_d != CntW'(SKID_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != '0);
    assign {out_illegal, out_rd, out_b, out_a, out_opcode} = head_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vector table plus handshake/flush/reset sequences.
// Expected out_illegal follows ALU_DECODE_ILLEGAL_EN.
module tb_alu_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_rs1_val;
    logic [63:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

`ifdef ALU_DECODE_ILLEGAL_EN
    localparam logic IllExp = 1'b1;
`else
    localparam logic IllExp = 1'b0;
`endif

    alu_decode_stage #(
        .XLEN       (64),
        .SKID_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] op, input logic [63:0] a,
                             input logic [63:0] b, input logic [4:0] rd, input logic ill);
        checks++;
        if (out_valid !== 1'b1 || out_opcode !== op || out_a !== a || out_b !== b ||
            out_rd !== rd || out_illegal !== ill) begin
            errors++;
            $display("FAIL %s: got v=%b op=%b a=%h b=%h rd=%0d ill=%b, expected v=1 op=%b a=%h b=%h rd=%0d ill=%b",
                     name, out_valid, out_opcode, out_a, out_b, out_rd, out_illegal,
                     op, a, b, rd, ill);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [63:0] rs1, input logic [63:0] rs2);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_opcode !== 4'd0 || out_a !== 64'd0 ||
            out_b !== 64'd0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s: got v=%b rdy=%b op=%b a=%h b=%h rd=%0d ill=%b, expected all 0 with rdy=1",
                     name, out_valid, in_ready, out_opcode, out_a, out_b, out_rd, out_illegal);
        end
    endtask

    initial begin
        vecs[0]  = '{"sub",   32'h402081B3, 64'd5, 64'd7, 4'b1000, 64'd5, 64'd7, 5'd3, 1'b0};
        vecs[1]  = '{"srai",  32'h43F0D093, 64'h8000_0000_0000_0000, 64'd1, 4'b1101,
                     64'h8000_0000_0000_0000, 64'h3F, 5'd1, 1'b0};
        vecs[2]  = '{"addi",  32'hFFF00093, 64'h123, 64'd9, 4'b0000, 64'h123,
                     64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b0};
        vecs[3]  = '{"bltu",  32'h0020E063, 64'd11, 64'd22, 4'b0011, 64'd11, 64'd22, 5'd0, 1'b0};
        vecs[4]  = '{"beq",   32'h00208063, 64'd33, 64'd44, 4'b1000, 64'd33, 64'd44, 5'd0, 1'b0};
        vecs[5]  = '{"lw",    32'hFFC0A283, 64'h1000, 64'd1, 4'b0000, 64'h1000,
                     64'hFFFF_FFFF_FFFF_FFFC, 5'd5, 1'b0};
        vecs[6]  = '{"sw",    32'h0020A423, 64'h2000, 64'hAB, 4'b0000, 64'h2000, 64'd8, 5'd0, 1'b0};
        vecs[7]  = '{"lui",   32'h800003B7, 64'd77, 64'd88, 4'b0000, 64'd0,
                     64'hFFFF_FFFF_8000_0000, 5'd7, 1'b0};
        vecs[8]  = '{"add",   32'h00208233, 64'd100, 64'd200, 4'b0000, 64'd100, 64'd200, 5'd4, 1'b0};
        vecs[9]  = '{"bad_opc", 32'h0000007F, 64'd1, 64'd2, 4'b0000, 64'd0, 64'd0, 5'd0, IllExp};
        vecs[10] = '{"sltu",  32'h0020B233, 64'd3, 64'd4, 4'b0011, 64'd3, 64'd4, 5'd4, 1'b0};
        vecs[11] = '{"xori",  32'h7FF0C093, 64'h55, 64'd0, 4'b0100, 64'h55, 64'h7FF, 5'd1, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
        step();
        step();
        rst = 1'b0;
        check_zero("reset");

        // Decode table: accept, check 1 cycle later, then drain.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
            step();
            in_valid = 1'b0;
            check_out(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].ill);
            step();
            check_bit({vecs[i].name, "_drained"}, out_valid, 1'b0);
        end

        // Backpressure: three offered, two accepted, held stable while stalled.
        out_ready = 1'b0;
        drive(vecs[0].instr, vecs[0].rs1, vecs[0].rs2);
        step();
        check_bit("bp_ready_after_1", in_ready, 1'b1);
        drive(vecs[8].instr, vecs[8].rs1, vecs[8].rs2);
        step();
        check_bit("bp_ready_after_2", in_ready, 1'b0);
        drive(vecs[11].instr, vecs[11].rs1, vecs[11].rs2);
        step();
        step();
        check_bit("bp_ready_held", in_ready, 1'b0);
        check_out("bp_head_stable", 4'b1000, 64'd5, 64'd7, 5'd3, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_out("bp_second", 4'b0000, 64'd100, 64'd200, 5'd4, 1'b0);
        check_bit("bp_ready_back", in_ready, 1'b1);
        step();
        check_bit("bp_third_dropped", out_valid, 1'b0);

        // Push and pop together at count 1.
        out_ready = 1'b0;
        drive(vecs[4].instr, vecs[4].rs1, vecs[4].rs2);
        step();
        drive(vecs[10].instr, vecs[10].rs1, vecs[10].rs2);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_out("pp_new_head", 4'b0011, 64'd3, 64'd4, 5'd4, 1'b0);
        check_bit("pp_ready", in_ready, 1'b1);
        step();
        check_bit("pp_count_was_1", out_valid, 1'b0);

        // Flush at count 2 with an offered op, then at count 1 with an accepted push.
        out_ready = 1'b0;
        drive(vecs[0].instr, vecs[0].rs1, vecs[0].rs2);
        step();
        step();
        drive(vecs[2].instr, vecs[2].rs1, vecs[2].rs2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_bit("flush2_valid", out_valid, 1'b0);
        check_bit("flush2_ready", in_ready, 1'b1);
        drive(vecs[0].instr, vecs[0].rs1, vecs[0].rs2);
        step();
        drive(vecs[2].instr, vecs[2].rs1, vecs[2].rs2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_bit("flush1_push_dropped", out_valid, 1'b0);
        step();
        check_bit("flush1_nothing_later", out_valid, 1'b0);

        // Reset mid-stream.
        out_ready = 1'b0;
        drive(vecs[1].instr, vecs[1].rs1, vecs[1].rs2);
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("mid_reset");
        step();
        check_zero("mid_reset_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
